// File: rtl/fir_128_mdc_package.sv
// Shared types and default sizing for the FIR-128 MDC control sequencer.
package fir_128_mdc_package;

    localparam int unsigned FIR_AW_DEFAULT   = 32;
    localparam int unsigned FIR_LW_DEFAULT   = 16;
    localparam int unsigned TILE_MAX_DEFAULT = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE
    } ctrl_state_t;

    // Job registers as presented by the register file.
    typedef struct packed {
        logic [FIR_AW_DEFAULT-1:0] x_base;
        logic [FIR_AW_DEFAULT-1:0] y_base;
        logic [FIR_LW_DEFAULT-1:0] len;
    } ctrl_fsm_cfg_t;

endpackage

// File: rtl/fir_128_mdc_tile_cnt.sv
// Tile datapath: remaining length, running source/sink addresses, tile index
// and the size of the tile currently in flight.
module fir_128_mdc_tile_cnt
    import fir_128_mdc_package::*;
#(
    parameter int unsigned AW       = FIR_AW_DEFAULT,
    parameter int unsigned LW       = FIR_LW_DEFAULT,
    parameter int unsigned TILE_MAX = TILE_MAX_DEFAULT
) (
    input  logic          clk_i,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [AW-1:0] x_base_i,
    input  logic [AW-1:0] y_base_i,
    input  logic [LW-1:0] len_i,
    input  logic          latch_tsz_i,
    input  logic          step_i,
    output logic [LW-1:0] tsz_o,
    output logic [AW-1:0] xa_o,
    output logic [AW-1:0] ya_o,
    output logic [LW-1:0] tile_idx_o,
    output logic          empty_o,
    output logic          last_o
);

    logic [LW-1:0] rem_q;
    logic [LW-1:0] tsz_q;
    logic [LW-1:0] idx_q;
    logic [AW-1:0] xa_q;
    logic [AW-1:0] ya_q;
    logic [LW-1:0] tsz_next;
    logic [AW-1:0] byte_step;

    // Next tile size is min(rem, TILE_MAX); byte stride is 4*tsz zero-extended.
    always_comb begin
        tsz_next  = (rem_q < LW'(TILE_MAX)) ? rem_q : LW'(TILE_MAX);
        byte_step = AW'({tsz_q, 2'b00});
    end

    // Load on job start, capture tile size per tile, advance on tile completion.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            rem_q <= '0;
            tsz_q <= '0;
            idx_q <= '0;
            xa_q  <= '0;
            ya_q  <= '0;
        end else if (load_i) begin
            rem_q <= len_i;
            idx_q <= '0;
            xa_q  <= x_base_i;
            ya_q  <= y_base_i;
        end else begin
            if (latch_tsz_i) begin
                tsz_q <= tsz_next;
            end
            if (step_i) begin
                rem_q <= rem_q - tsz_q;
                xa_q  <= xa_q + byte_step;
                ya_q  <= ya_q + byte_step;
                idx_q <= idx_q + LW'(1);
            end
        end
    end

    assign tsz_o      = tsz_q;
    assign xa_o       = xa_q;
    assign ya_o       = ya_q;
    assign tile_idx_o = idx_q;
    assign empty_o    = (rem_q == '0);
    // The tile in flight consumes everything that is left.
    assign last_o     = (rem_q == tsz_q);

endmodule

// File: rtl/fir_128_mdc_ctrl_fsm.sv
// Job sequencer: splits a job into tiles, kicks source and sink per tile and
// waits for both done pulses before moving on; flags end of job.
module fir_128_mdc_ctrl_fsm
    import fir_128_mdc_package::*;
#(
    parameter int unsigned AW       = FIR_AW_DEFAULT,
    parameter int unsigned LW       = FIR_LW_DEFAULT,
    parameter int unsigned TILE_MAX = TILE_MAX_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [AW-1:0] x_base_i,
    input  logic [AW-1:0] y_base_i,
    input  logic [LW-1:0] len_i,
    output logic          src_req_o,
    output logic [AW-1:0] src_addr_o,
    output logic [LW-1:0] src_size_o,
    input  logic          src_done_i,
    output logic          snk_req_o,
    output logic [AW-1:0] snk_addr_o,
    output logic [LW-1:0] snk_size_o,
    input  logic          snk_done_i,
    output logic          eng_clear_o,
    output logic          busy_o,
    output logic          evt_done_o,
    output logic [LW-1:0] tile_idx_o
);

    ctrl_state_t   state_q, state_d;
    logic          sdl_q, sdl_d;
    logic          kdl_q, kdl_d;
    logic [AW-1:0] src_addr_q;
    logic [AW-1:0] snk_addr_q;
    logic          kill;
    logic          src_seen, snk_seen;
    logic          cnt_load, cnt_latch, cnt_step;
    logic          cnt_empty, cnt_last;
    logic [AW-1:0] cnt_xa, cnt_ya;
    logic [LW-1:0] cnt_tsz;

    assign kill = rst_i | clear_i;

    fir_128_mdc_tile_cnt #(
        .AW       (AW),
        .LW       (LW),
        .TILE_MAX (TILE_MAX)
    ) u_tile_cnt (
        .clk_i       (clk_i),
        .clear_i     (kill),
        .load_i      (cnt_load),
        .x_base_i    (x_base_i),
        .y_base_i    (y_base_i),
        .len_i       (len_i),
        .latch_tsz_i (cnt_latch),
        .step_i      (cnt_step),
        .tsz_o       (cnt_tsz),
        .xa_o        (cnt_xa),
        .ya_o        (cnt_ya),
        .tile_idx_o  (tile_idx_o),
        .empty_o     (cnt_empty),
        .last_o      (cnt_last)
    );

    // Next-state, done latching and pulse outputs; reset/clear overrides everything.
    always_comb begin
        state_d     = state_q;
        sdl_d       = sdl_q;
        kdl_d       = kdl_q;
        cnt_load    = 1'b0;
        cnt_latch   = 1'b0;
        cnt_step    = 1'b0;
        eng_clear_o = 1'b0;
        src_req_o   = 1'b0;
        snk_req_o   = 1'b0;
        evt_done_o  = 1'b0;
        src_seen    = sdl_q | src_done_i;
        snk_seen    = kdl_q | snk_done_i;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_load    = 1'b1;
                    eng_clear_o = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                sdl_d = 1'b0;
                kdl_d = 1'b0;
                if (cnt_empty) begin
                    state_d = DONE;
                end else begin
                    cnt_latch = 1'b1;
                    state_d   = START;
                end
            end
            START, WAIT: begin
                // Dones arriving with the req pulse count, so a tile can finish
                // straight from START and keep the done-to-next-req latency fixed.
                if (state_q == START) begin
                    src_req_o = 1'b1;
                    snk_req_o = 1'b1;
                end
                sdl_d   = src_seen;
                kdl_d   = snk_seen;
                state_d = WAIT;
                if (src_seen && snk_seen) begin
                    cnt_step = 1'b1;
                    sdl_d    = 1'b0;
                    kdl_d    = 1'b0;
                    state_d  = cnt_last ? DONE : LOAD;
                end
            end
            DONE: begin
                evt_done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (kill) begin
            state_d     = IDLE;
            sdl_d       = 1'b0;
            kdl_d       = 1'b0;
            cnt_load    = 1'b0;
            cnt_latch   = 1'b0;
            cnt_step    = 1'b0;
            eng_clear_o = 1'b0;
            src_req_o   = 1'b0;
            snk_req_o   = 1'b0;
            evt_done_o  = 1'b0;
        end
    end

    // State and done-latch registers.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            sdl_q   <= 1'b0;
            kdl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sdl_q   <= sdl_d;
            kdl_q   <= kdl_d;
        end
    end

    // Tile addresses are frozen at LOAD so they hold while the counters advance.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            src_addr_q <= '0;
            snk_addr_q <= '0;
        end else if (cnt_latch) begin
            src_addr_q <= cnt_xa;
            snk_addr_q <= cnt_ya;
        end
    end

    assign src_addr_o = src_addr_q;
    assign snk_addr_o = snk_addr_q;
    assign src_size_o = cnt_tsz;
    assign snk_size_o = cnt_tsz;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_fir_128_mdc_ctrl_fsm.sv
// Randomized self-checking bench: each job is planned up front from the tiling
// and latency rules, then replayed cycle by cycle against the DUT.
module tb_fir_128_mdc_ctrl_fsm;

    localparam int unsigned AW   = 32;
    localparam int unsigned LW   = 16;
    localparam int unsigned TM   = 128;
    localparam int          MAXC = 256;

    logic          clk = 1'b0;
    logic          rst_i, clear_i, start_i;
    logic [AW-1:0] x_base_i, y_base_i;
    logic [LW-1:0] len_i;
    logic          src_req_o, snk_req_o, src_done_i, snk_done_i;
    logic [AW-1:0] src_addr_o, snk_addr_o;
    logic [LW-1:0] src_size_o, snk_size_o, tile_idx_o;
    logic          eng_clear_o, busy_o, evt_done_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-cycle plan: expected {eng_clear, src_req, snk_req, evt_done, busy}.
    logic [4:0] exp_vec [MAXC];
    bit         skip    [MAXC];
    bit         d_start [MAXC];
    bit         d_src   [MAXC];
    bit         d_snk   [MAXC];
    int         tile_at [MAXC];
    int         hold_at [MAXC];

    always #5 clk = ~clk;

    fir_128_mdc_ctrl_fsm #(
        .AW       (AW),
        .LW       (LW),
        .TILE_MAX (TM)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .x_base_i    (x_base_i),
        .y_base_i    (y_base_i),
        .len_i       (len_i),
        .src_req_o   (src_req_o),
        .src_addr_o  (src_addr_o),
        .src_size_o  (src_size_o),
        .src_done_i  (src_done_i),
        .snk_req_o   (snk_req_o),
        .snk_addr_o  (snk_addr_o),
        .snk_size_o  (snk_size_o),
        .snk_done_i  (snk_done_i),
        .eng_clear_o (eng_clear_o),
        .busy_o      (busy_o),
        .evt_done_o  (evt_done_o),
        .tile_idx_o  (tile_idx_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] tile_addr(input logic [31:0] base, input int i);
        return base + 32'(4 * TM * i);
    endfunction

    function automatic int tile_size(input int len, input int i);
        int left;
        left = len - int'(TM) * i;
        return (left < int'(TM)) ? left : int'(TM);
    endfunction

    // mode 0: random done delays; 1: snk early / same cycle / in req cycle;
    // 2: long waits with start_i retried mid-tile. abort_kind 1=rst, 2=clear in tile 1.
    task automatic run_job(input logic [31:0] x, input logic [31:0] y, input int len,
                           input int mode, input int abort_kind);
        int  r, i, rem, ds, dk, later, ncyc, kc, last_c;
        bit  aborted;
        for (int c = 0; c < MAXC; c++) begin
            exp_vec[c] = '0; skip[c] = 1'b0; d_start[c] = 1'b0;
            d_src[c] = 1'b0; d_snk[c] = 1'b0; tile_at[c] = -1; hold_at[c] = -1;
        end
        kc = -1; aborted = 1'b0; last_c = 0; ncyc = 0;
        exp_vec[0] = 5'b10000;
        d_start[0] = 1'b1;
        if (len == 0) begin
            exp_vec[2][1] = 1'b1;
            last_c = 2;
        end else begin
            rem = len; r = 2; i = 0;
            while (rem > 0 && !aborted) begin
                tile_at[r] = i;
                exp_vec[r][3] = 1'b1;
                exp_vec[r][2] = 1'b1;
                if (mode == 1) begin
                    ds = (i == 0) ? 6 : (i == 1) ? 2 : 0;
                    dk = (i == 0) ? 1 : (i == 1) ? 2 : 0;
                end else if (mode == 2 || (abort_kind != 0 && i == 1)) begin
                    ds = $urandom_range(3, 6); dk = $urandom_range(3, 6);
                end else begin
                    ds = $urandom_range(0, 6); dk = $urandom_range(0, 6);
                end
                if (abort_kind != 0 && i == 1) begin
                    kc = r + 1;
                    skip[kc] = 1'b1;
                    d_src[kc] = 1'b1;
                    d_snk[kc + 1] = 1'b1;
                    for (int c = 1; c < kc; c++) exp_vec[c][0] = 1'b1;
                    ncyc = kc + 4;
                    aborted = 1'b1;
                end else begin
                    d_src[r + ds] = 1'b1;
                    d_snk[r + dk] = 1'b1;
                    later = r + ((ds > dk) ? ds : dk);
                    hold_at[later] = i;
                    if (mode == 2) begin
                        d_start[r] = 1'b1;
                        d_start[later] = 1'b1;
                    end else if ($urandom_range(0, 2) == 0) begin
                        d_start[r + int'($urandom_range(0, later - r))] = 1'b1;
                    end
                    rem -= tile_size(len, i);
                    if (rem == 0) begin
                        exp_vec[later + 1][1] = 1'b1;
                        last_c = later + 1;
                        if ($urandom_range(0, 1) == 1) begin
                            d_src[later + 1] = 1'b1;
                            d_start[later + 1] = 1'b1;
                        end
                    end else begin
                        if ($urandom_range(0, 1) == 1) begin
                            d_src[later + 1] = 1'b1;
                            d_snk[later + 1] = 1'b1;
                        end
                        r = later + 2;
                    end
                    i++;
                end
            end
        end
        if (!aborted) begin
            for (int c = 1; c <= last_c; c++) exp_vec[c][0] = 1'b1;
            ncyc = last_c + 2;
        end

        for (int c = 0; c < ncyc; c++) begin
            start_i = d_start[c];
            if (c == 0) begin
                x_base_i = x; y_base_i = y; len_i = LW'(len);
            end else begin
                x_base_i = $urandom; y_base_i = $urandom; len_i = LW'($urandom);
            end
            src_done_i = d_src[c];
            snk_done_i = d_snk[c];
            rst_i   = (abort_kind == 1 && c == kc);
            clear_i = (abort_kind == 2 && c == kc);
            @(negedge clk);
            if (!skip[c])
                check_eq($sformatf("ctl_vec len=%0d c=%0d", len, c),
                         64'({eng_clear_o, src_req_o, snk_req_o, evt_done_o, busy_o}),
                         64'(exp_vec[c]));
            if (tile_at[c] >= 0) begin
                check_eq($sformatf("src_addr t%0d", tile_at[c]), 64'(src_addr_o),
                         64'(tile_addr(x, tile_at[c])));
                check_eq($sformatf("snk_addr t%0d", tile_at[c]), 64'(snk_addr_o),
                         64'(tile_addr(y, tile_at[c])));
                check_eq($sformatf("src_size t%0d", tile_at[c]), 64'(src_size_o),
                         64'(tile_size(len, tile_at[c])));
                check_eq($sformatf("snk_size t%0d", tile_at[c]), 64'(snk_size_o),
                         64'(tile_size(len, tile_at[c])));
                check_eq($sformatf("tile_idx t%0d", tile_at[c]), 64'(tile_idx_o),
                         64'(tile_at[c]));
            end
            if (hold_at[c] >= 0) begin
                check_eq($sformatf("src_addr_hold t%0d", hold_at[c]), 64'(src_addr_o),
                         64'(tile_addr(x, hold_at[c])));
                check_eq($sformatf("snk_size_hold t%0d", hold_at[c]), 64'(snk_size_o),
                         64'(tile_size(len, hold_at[c])));
            end
            if (kc >= 0 && c == kc + 1) begin
                check_eq("abort_addrs", 64'({src_addr_o, snk_addr_o}), 64'(0));
                check_eq("abort_sizes_idx", 64'({src_size_o, snk_size_o, tile_idx_o}), 64'(0));
            end
            @(posedge clk);
            #1;
        end
        start_i = 1'b0; src_done_i = 1'b0; snk_done_i = 1'b0;
        rst_i = 1'b0; clear_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
        x_base_i = '0; y_base_i = '0; len_i = '0;
        src_done_i = 1'b0; snk_done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_ctl", 64'({eng_clear_o, src_req_o, snk_req_o, evt_done_o, busy_o}),
                 64'(0));
        check_eq("reset_addrs", 64'({src_addr_o, snk_addr_o}), 64'(0));
        check_eq("reset_sizes_idx", 64'({src_size_o, snk_size_o, tile_idx_o}), 64'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        run_job(32'h0000_1000, 32'h0000_2000, 300, 0, 0);
        run_job(32'h0000_3000, 32'h0000_4000, 0, 0, 0);
        run_job(32'h0000_1000, 32'h0000_2000, 300, 1, 0);
        run_job(32'h0000_5000, 32'h0000_6000, 300, 2, 0);
        run_job(32'h0000_1000, 32'h0000_2000, 300, 0, 1);
        run_job(32'h0000_8000, 32'h0000_9000, 16, 0, 0);
        run_job(32'h0000_1000, 32'h0000_2000, 300, 0, 2);
        run_job(32'h0000_A000, 32'h0000_B000, 16, 0, 0);
        run_job(32'hFFFF_FE00, 32'h0000_7000, 256, 0, 0);
        run_job(32'h0001_0000, 32'h0002_0000, 128, 0, 0);
        run_job(32'h0001_0000, 32'h0002_0000, 129, 0, 0);
        run_job(32'h0001_0000, 32'h0002_0000, 1, 0, 0);
        for (int k = 0; k < 25; k++) begin
            run_job($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    int'($urandom_range(0, 700)), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
